// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: operand/result bundle between the datapath and the mult/div unit
// Signals: start_in/op_in/A_in/B_in request an operation; hi_out/lo_out are the
// architectural HI/LO registers; busy_out stalls fetch; done_out pulses on
// completion; div0_out exists only when MULDIV_DIV0_EN is defined.
interface mips_muldiv_if #(parameter int WIDTH = 32) ();
  logic             start_in;
  logic [2:0]       op_in;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy_out;
  logic             done_out;
`ifdef MULDIV_DIV0_EN
  logic             div0_out;
`endif
  modport master (
    output start_in, op_in, A_in, B_in,
    input  hi_out, lo_out, busy_out, done_out
`ifdef MULDIV_DIV0_EN
    , input div0_out
`endif
  );
  modport slave (
    input  start_in, op_in, A_in, B_in,
    output hi_out, lo_out, busy_out, done_out
`ifdef MULDIV_DIV0_EN
    , output div0_out
`endif
  );
endinterface

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative shift-add multiplier / restoring divider with HI/LO registers
// Ports: clk (rising edge), reset (async, active-high), bus (mips_muldiv_if.slave).
// op_in: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
// An operation takes WIDTH RUN cycles plus one SIGN cycle, then a DONE pulse.
// MULDIV_DIV0_EN: divide by zero skips to DONE, leaves HI/LO alone and raises div0_out.
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          reset,
  mips_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;
  state_t             state, state_nx;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb, hi, lo;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_q, neg_r;
  logic               start, arith, op_div, sa, sb, skip;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     msum, dsub;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  assign start  = bus.start_in && state == IDLE;
  assign arith  = start && !bus.op_in[2];
  assign op_div = bus.op_in[1];
  assign sa     = !bus.op_in[0] && bus.A_in[WIDTH-1];
  assign sb     = !bus.op_in[0] && bus.B_in[WIDTH-1];
  assign a_abs  = sa ? -bus.A_in : bus.A_in;
  assign b_abs  = sb ? -bus.B_in : bus.B_in;
`ifdef MULDIV_DIV0_EN
  logic div_zero, div0;
  assign div_zero     = arith && op_div && bus.B_in == '0;
  assign skip         = div_zero;
  assign bus.div0_out = div0;
`else
  assign skip = 1'b0;
`endif
  // acc holds product (high:low) for multiply, remainder:quotient for divide
  assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
  assign mul_nx = acc[0] ? {msum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  assign dsub   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
  assign div_nx = dsub[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                              : {dsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign prod   = neg_q ? -acc : acc;
  assign res_hi = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
  assign bus.hi_out   = hi;
  assign bus.lo_out   = lo;
  assign bus.busy_out = state == RUN || state == SIGN;
  assign bus.done_out = state == DONE;
  always_comb begin
    state_nx = state == IDLE ? (arith ? (skip ? DONE : RUN) : IDLE)
             : state == RUN  ? (cnt == CNT_W'(1) ? SIGN : RUN)
             : state == SIGN ? DONE : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_DIV0_EN
      div0   <= 1'b0;
`endif
    end else begin
      if (arith) begin
        acc    <= {{WIDTH{1'b0}}, op_div ? a_abs : b_abs};
        opb    <= op_div ? b_abs : a_abs;
        cnt    <= CNT_W'(WIDTH);
        is_div <= op_div;
        // a zero divisor yields an all-ones quotient that must stay unsigned
        neg_q  <= (sa ^ sb) && (!op_div || bus.B_in != '0);
        neg_r  <= op_div && sa;
      end else if (start && bus.op_in == 3'b100) hi <= bus.A_in;
      else if (start && bus.op_in == 3'b101) lo <= bus.A_in;
      if (state == RUN) begin
        acc <= is_div ? div_nx : mul_nx;
        cnt <= cnt - 1'b1;
      end
      if (state == SIGN) begin
        hi <= res_hi;
        lo <= res_lo;
      end
`ifdef MULDIV_DIV0_EN
      div0 <= div_zero;
`endif
    end
  end
endmodule
